result_display: RTL and testbench

// Reader side of the accumulator result bus. Takes the binary running total,

---
 rtl/result_display.sv | 177 +++++++++++++++++
 tb/tb_result_display.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_display.sv
// result_display
// Reader side of the accumulator result bus. The unsigned running total is
// converted to BCD by a sequential shift-add-3 (double-dabble) engine. The
// digits then drive DIGITS active-low seven-segment displays, with optional
// leading-zero blanking. A new conversion starts automatically whenever
// value_i differs from the last value converted.
//
// Ports
//   clk_i    system clock, rising edge
//   rst_ni   asynchronous reset, active-low
//   value_i  unsigned binary value to display
//   hex_no   segments, digit k = [7k+6:7k], order {g,f,e,d,c,b,a}, active-low
//   busy_o   high while a conversion is in progress
//   valid_o  high once hex_no shows a converted value (sticky until reset)
//
// Handshake: there is none on value_i. The block samples value_i whenever it
// is idle and the value differs from the last value converted, or when a
// conversion is pending after reset. Changes to value_i during a conversion
// are picked up in the idle cycle that follows it. The FSM state is held in
// state_q.
module result_display #(
  parameter int WIDTH    = 10,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [WIDTH-1:0]    value_i,
  output logic [7*DIGITS-1:0] hex_no,
  output logic                busy_o,
  output logic                valid_o
);

  // One nibble beyond the displayed digits catches values >= 10^DIGITS.
  localparam int BW = 4 * DIGITS + 4;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [WIDTH-1:0]    snap_q, snap_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;

  logic [BW-1:0]       bcd_adj;
  logic [7*DIGITS-1:0] hex_dec;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  // Add-3 correction, per nibble with no carry between nibbles.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < DIGITS + 1; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) begin
        bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
    end
  end

  // Segment decode of the finished BCD value. Overflow also covers a set bit
  // shifted out of the top nibble (ovf_q). Without it, a value that is too
  // large for even the extra nibble would wrap and show wrong digits.
  always_comb begin
    logic       lead_zero;
    logic       over;
    logic [3:0] digit;
    hex_dec   = '1;
    lead_zero = 1'b1;
    over      = ovf_q | (bcd_q[BW-1 -: 4] != 4'd0);
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit = bcd_q[4*k +: 4];
      if (digit != 4'd0) lead_zero = 1'b0;
      if (over) begin
        hex_dec[7*k +: 7] = 7'b0111111;
      end else if ((BLANK_LZ != 0) && lead_zero && (k > 0)) begin
        hex_dec[7*k +: 7] = 7'b1111111;
      end else begin
        hex_dec[7*k +: 7] = seg7(digit);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    snap_d  = snap_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    hex_d   = hex_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q || (value_i != snap_q)) begin
          state_d = ST_SHIFT;
          bin_d   = value_i;
          snap_d  = value_i;
          bcd_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
        ovf_d          = ovf_q | bcd_adj[BW-1];
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        hex_d   = hex_dec;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      snap_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b1;
      ovf_q   <= 1'b0;
      hex_q   <= '1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      snap_q  <= snap_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign hex_no  = hex_q;
  assign busy_o  = busy_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display. Three instances are used:
//   a: WIDTH=10, DIGITS=4, blanking on
//   b: DIGITS=2
//   c: blanking off
// Expected segment patterns come from a decimal reference model.
module tb_result_display;

  logic        clk;
  logic        rst_n;
  logic [9:0]  value_a, value_b, value_c;
  logic [27:0] hex_a, hex_c;
  logic [13:0] hex_b;
  logic        busy_a, busy_b, busy_c;
  logic        valid_a, valid_b, valid_c;

  result_display #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .value_i(value_a),
    .hex_no(hex_a), .busy_o(busy_a), .valid_o(valid_a)
  );

  result_display #(.WIDTH(10), .DIGITS(2), .BLANK_LZ(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .value_i(value_b),
    .hex_no(hex_b), .busy_o(busy_b), .valid_o(valid_b)
  );

  result_display #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(0)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .value_i(value_c),
    .hex_no(hex_c), .busy_o(busy_c), .valid_o(valid_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [27:0] exp_q[$];
  logic [27:0] exp_b_q[$];
  logic [27:0] exp_c_q[$];

  logic busy_prev[3];
  int   busy_len[3];
  int   done_cyc[3];
  int   prev_done_cyc[3];

  task automatic check_eq(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       seg_of = 7'b1000000;
      1:       seg_of = 7'b1111001;
      2:       seg_of = 7'b0100100;
      3:       seg_of = 7'b0110000;
      4:       seg_of = 7'b0011001;
      5:       seg_of = 7'b0010010;
      6:       seg_of = 7'b0000010;
      7:       seg_of = 7'b1111000;
      8:       seg_of = 7'b0000000;
      9:       seg_of = 7'b0010000;
      default: seg_of = 7'b0111111;
    endcase
  endfunction

  function automatic logic [27:0] ref_hex(input int v, input int nd, input bit blank);
    logic [27:0] r;
    int          p;
    int          q;
    r = '0;
    p = 1;
    for (int k = 0; k < nd; k++) p = p * 10;
    if (v >= p) begin
      for (int k = 0; k < nd; k++) r[7*k +: 7] = 7'b0111111;
    end else begin
      q = 1;
      for (int k = 0; k < nd; k++) begin
        if (blank && k > 0 && v < q) r[7*k +: 7] = 7'b1111111;
        else                         r[7*k +: 7] = seg_of((v / q) % 10);
        q = q * 10;
      end
    end
    return r;
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return exp_q.size();
      1:       return exp_b_q.size();
      default: return exp_c_q.size();
    endcase
  endfunction

  // ---------------- monitor ----------------
  // A conversion is complete when busy drops while out of reset.
  task automatic mon_step(input int i, input logic busy, input logic valid,
                          input logic [27:0] hex);
    logic [27:0] e;
    if (!rst_n) begin
      busy_prev[i] = 1'b0;
      busy_len[i]  = 0;
    end else begin
      if (busy) begin
        busy_len[i]++;
      end else if (busy_prev[i]) begin
        if (qsize(i) == 0) begin
          check_eq($sformatf("unexpected_done_%0d", i), 28'(qsize(i)), 28'd1);
        end else begin
          case (i)
            0:       e = exp_q.pop_front();
            1:       e = exp_b_q.pop_front();
            default: e = exp_c_q.pop_front();
          endcase
          check_eq($sformatf("hex_%0d", i), hex, e);
        end
        check_eq($sformatf("valid_%0d", i), 28'(valid), 28'd1);
        check_eq($sformatf("busy_len_%0d", i), 28'(busy_len[i]), 28'd11);
        busy_len[i]      = 0;
        prev_done_cyc[i] = done_cyc[i];
        done_cyc[i]      = cyc;
      end
      busy_prev[i] = busy;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    mon_step(0, busy_a, valid_a, hex_a);
    mon_step(1, busy_b, valid_b, {14'd0, hex_b});
    mon_step(2, busy_c, valid_c, hex_c);
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int i, input int v);
    case (i)
      0:       exp_q.push_back(ref_hex(v, 4, 1'b1));
      1:       exp_b_q.push_back(ref_hex(v, 2, 1'b1));
      default: exp_c_q.push_back(ref_hex(v, 4, 1'b0));
    endcase
  endtask

  // Wait (bounded) until instance i has consumed all expected results.
  task automatic wait_drain(input int i, input int max, output int n);
    n = 0;
    while (qsize(i) != 0 && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (qsize(i) != 0) begin
      check_eq($sformatf("timeout_%0d", i), 28'(qsize(i)), 28'd0);
    end
  endtask

  task automatic run(input int i, input int v);
    int   n;
    logic changed;
    case (i)
      0:       begin changed = (value_a != 10'(v)); value_a = 10'(v); end
      1:       begin changed = (value_b != 10'(v)); value_b = 10'(v); end
      default: begin changed = (value_c != 10'(v)); value_c = 10'(v); end
    endcase
    if (changed) push_exp(i, v);
    wait_drain(i, 40, n);
  endtask

  // ---------------- stimulus ----------------
  int n;
  int v;

  initial begin
    for (int i = 0; i < 3; i++) begin
      busy_prev[i]     = 1'b0;
      busy_len[i]      = 0;
      done_cyc[i]      = 0;
      prev_done_cyc[i] = 0;
    end
    rst_n   = 1'b0;
    value_a = 10'd0;
    value_b = 10'd100;
    value_c = 10'd5;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_hex_a",   hex_a, 28'hfffffff);
    check_eq("rst_busy_a",  28'(busy_a), 28'd0);
    check_eq("rst_valid_a", 28'(valid_a), 28'd0);
    check_eq("rst_hex_b",   {14'd0, hex_b}, 28'h0003fff);
    check_eq("rst_valid_b", 28'(valid_b), 28'd0);
    check_eq("rst_hex_c",   hex_c, 28'hfffffff);
    check_eq("rst_busy_c",  28'(busy_c), 28'd0);

    // Reset forces one conversion of whatever is on value_i.
    push_exp(0, 0);
    push_exp(1, 100);
    push_exp(2, 5);
    rst_n = 1'b1;
    wait_drain(0, 40, n);
    check_eq("t1_latency", 28'(n), 28'd12);
    wait_drain(1, 40, n);
    wait_drain(2, 40, n);

    // Main instance: boundaries, then random values.
    run(0, 1023);
    run(0, 9);
    run(0, 10);
    run(0, 999);
    run(0, 1000);
    run(0, 100);
    for (int k = 0; k < 8; k++) begin
      v = int'($urandom_range(0, 1023));
      if (10'(v) == value_a) v = (v + 1) % 1024;
      run(0, v);
    end

    // Two-digit instance: overflow dashes and normal values.
    run(1, 99);
    run(1, 5);
    run(1, 1000);
    run(1, 0);
    run(1, 10);
    run(1, 1023);

    // No blanking instance.
    run(2, 0);
    run(2, 1023);
    run(2, 40);

    // Value change in the middle of a conversion.
    run(0, 0);
    value_a = 10'd7;
    push_exp(0, 7);
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    value_a = 10'd42;
    push_exp(0, 42);
    wait_drain(0, 60, n);
    check_eq("t3_gap", 28'(done_cyc[0] - prev_done_cyc[0]), 28'd12);

    // Reset in the middle of a conversion.
    run(0, 0);
    value_a = 10'd512;
    push_exp(0, 512);
    repeat (4) begin
      @(negedge clk);
      #1;
    end
    check_eq("t6_busy_mid", 28'(busy_a), 28'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_hex",   hex_a, 28'hfffffff);
    check_eq("t6_rst_busy",  28'(busy_a), 28'd0);
    check_eq("t6_rst_valid", 28'(valid_a), 28'd0);
    push_exp(1, int'(value_b));
    push_exp(2, int'(value_c));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_drain(0, 12, n);
    check_eq("t6_within", 28'(n <= 12), 28'd1);
    wait_drain(1, 40, n);
    wait_drain(2, 40, n);

    repeat (3) @(negedge clk);
    #1;
    check_eq("left_a", 28'(exp_q.size()), 28'd0);
    check_eq("left_b", 28'(exp_b_q.size()), 28'd0);
    check_eq("left_c", 28'(exp_c_q.size()), 28'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
